fp_bolme: RTL

Sequential IEEE-754 single-precision divider that computes `x1_i / x2_i` with a restoring shift-subtract loop, one quotient bit per clock. It is the inverse-operation companion to the multi-cycle FP multiplier in the arithmetic unit, and uses the same 32-bit operand/result format. A start/valid handshake lets the controlling FSM issue one division and wait for `gecerli_o`.

---
 rtl/fp_bolme.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fp_bolme.sv
// Sequential IEEE-754 single-precision divider (restoring, one quotient bit per clock).
// Optional round-to-nearest-even when FP_BOLME_RNE_EN is defined; truncation otherwise.
module fp_bolme (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        basla_i,
    input  logic [31:0] x1_i,
    input  logic [31:0] x2_i,
    output logic [31:0] sonuc_o,
    output logic        gecerli_o,
    output logic        mesgul_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORM,
        S_ROUND
    } state_t;

    state_t             state_reg;
    logic [31:0]        x1_reg;
    logic [31:0]        x2_reg;
    logic               sign_reg;
    logic signed [9:0]  exp_reg;
    logic [23:0]        m2_reg;
    logic [25:0]        rem_reg;
    logic [25:0]        q_reg;
    logic [4:0]         cnt_reg;
    logic [22:0]        mant_reg;
    logic               guard_reg;
    logic               sticky_reg;
    logic [31:0]        sonuc_reg;
    logic               gecerli_reg;
    logic               mesgul_reg;

    // Operand classification on the latched operands; exp=0 counts as zero
    logic zero1, zero2, inf1, inf2, nan1, nan2;
    logic sign_w, res_nan, res_inf, res_zero;

    always_comb begin
        zero1    = (x1_reg[30:23] == 8'h00);
        zero2    = (x2_reg[30:23] == 8'h00);
        inf1     = (x1_reg[30:23] == 8'hFF) && (x1_reg[22:0] == 23'd0);
        inf2     = (x2_reg[30:23] == 8'hFF) && (x2_reg[22:0] == 23'd0);
        nan1     = (x1_reg[30:23] == 8'hFF) && (x1_reg[22:0] != 23'd0);
        nan2     = (x2_reg[30:23] == 8'hFF) && (x2_reg[22:0] != 23'd0);
        sign_w   = x1_reg[31] ^ x2_reg[31];
        res_nan  = nan1 | nan2 | (zero1 & zero2) | (inf1 & inf2);
        res_inf  = zero2 | inf1;
        res_zero = zero1 | inf2;
    end

    // One restoring iteration
    logic        rem_ge;
    logic [25:0] rem_sub;
    logic [25:0] rem_shift;

    always_comb begin
        rem_ge    = (rem_reg >= {2'b00, m2_reg});
        rem_sub   = rem_ge ? (rem_reg - {2'b00, m2_reg}) : rem_reg;
        rem_shift = rem_sub << 1;
    end

    logic round_inc;
`ifdef FP_BOLME_RNE_EN
    assign round_inc = guard_reg & (sticky_reg | mant_reg[0]);
`else
    assign round_inc = 1'b0;
    logic unused_round_bits;
    assign unused_round_bits = ^{guard_reg, sticky_reg};
`endif

    // Carry out of the 23-bit mantissa leaves it at zero and bumps the exponent
    logic [23:0]       rnd_sum;
    logic signed [9:0] exp_rnd;

    always_comb begin
        rnd_sum = {1'b0, mant_reg} + {23'd0, round_inc};
        exp_rnd = exp_reg + $signed({9'd0, rnd_sum[23]});
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= S_IDLE;
            x1_reg      <= 32'd0;
            x2_reg      <= 32'd0;
            sign_reg    <= 1'b0;
            exp_reg     <= 10'sd0;
            m2_reg      <= 24'd0;
            rem_reg     <= 26'd0;
            q_reg       <= 26'd0;
            cnt_reg     <= 5'd0;
            mant_reg    <= 23'd0;
            guard_reg   <= 1'b0;
            sticky_reg  <= 1'b0;
            sonuc_reg   <= 32'd0;
            gecerli_reg <= 1'b0;
            mesgul_reg  <= 1'b0;
        end else begin
            gecerli_reg <= 1'b0;
            unique case (state_reg)
                S_IDLE: begin
                    // Busy stays up through the valid cycle and drops on the next idle edge
                    mesgul_reg <= basla_i;
                    if (basla_i) begin
                        x1_reg    <= x1_i;
                        x2_reg    <= x2_i;
                        state_reg <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_reg <= sign_w;
                    if (res_nan) begin
                        sonuc_reg   <= 32'h7FC0_0000;
                        gecerli_reg <= 1'b1;
                        state_reg   <= S_IDLE;
                    end else if (res_inf) begin
                        sonuc_reg   <= {sign_w, 8'hFF, 23'd0};
                        gecerli_reg <= 1'b1;
                        state_reg   <= S_IDLE;
                    end else if (res_zero) begin
                        sonuc_reg   <= {sign_w, 31'd0};
                        gecerli_reg <= 1'b1;
                        state_reg   <= S_IDLE;
                    end else begin
                        exp_reg   <= $signed({2'b00, x1_reg[30:23]})
                                   - $signed({2'b00, x2_reg[30:23]}) + 10'sd127;
                        m2_reg    <= {1'b1, x2_reg[22:0]};
                        rem_reg   <= {3'b001, x1_reg[22:0]};
                        q_reg     <= 26'd0;
                        cnt_reg   <= 5'd0;
                        state_reg <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem_reg <= rem_shift;
                    q_reg   <= {q_reg[24:0], rem_ge};
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd25) begin
                        state_reg <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (q_reg[25]) begin
                        mant_reg   <= q_reg[24:2];
                        guard_reg  <= q_reg[1];
                        sticky_reg <= q_reg[0] | (rem_reg != 26'd0);
                    end else begin
                        exp_reg    <= exp_reg - 10'sd1;
                        mant_reg   <= q_reg[23:1];
                        guard_reg  <= q_reg[0];
                        sticky_reg <= (rem_reg != 26'd0);
                    end
                    state_reg <= S_ROUND;
                end
                S_ROUND: begin
                    if (exp_rnd >= 10'sd255) begin
                        sonuc_reg <= {sign_reg, 8'hFF, 23'd0};
                    end else if (exp_rnd <= 10'sd0) begin
                        sonuc_reg <= {sign_reg, 31'd0};
                    end else begin
                        sonuc_reg <= {sign_reg, exp_rnd[7:0], rnd_sum[22:0]};
                    end
                    gecerli_reg <= 1'b1;
                    state_reg   <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign sonuc_o   = sonuc_reg;
    assign gecerli_o = gecerli_reg;
    assign mesgul_o  = mesgul_reg;

endmodule
